// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register.
//   usr_mode_e     : 3-bit operation codes on mode_i (0 hold .. 6 ASR, 7 hold)
//   usr_state_e    : burst controller states (IDLE / RUN)
//   usr_single_step: ops that never start a multi-step burst
package usr_pkg;

  localparam int unsigned USR_MODE_W = 3;

  typedef enum logic [USR_MODE_W-1:0] {
    USR_HOLD  = 3'd0,
    USR_SR    = 3'd1,
    USR_SL    = 3'd2,
    USR_LOAD  = 3'd3,
    USR_ROR   = 3'd4,
    USR_ROL   = 3'd5,
    USR_ASR   = 3'd6,
    USR_HOLD7 = 3'd7
  } usr_mode_e;

  typedef enum logic {
    USR_IDLE = 1'b0,
    USR_RUN  = 1'b1
  } usr_state_e;

  // Hold and load are idempotent, so a burst of them collapses to one step.
  // Rotate codes are deliberately excluded: with rotate compiled out they
  // behave as hold but must still count down a full burst.
  function automatic logic usr_single_step(input usr_mode_e m);
    return (m == USR_HOLD) || (m == USR_HOLD7) || (m == USR_LOAD);
  endfunction

endpackage : usr_pkg

// File: rtl/usr_shift_step.sv
// Combinational next-value function of the universal shift register.
// Macro: USR_ROTATE_EN -- when defined, ROR/ROL are implemented; otherwise
// those codes decode as hold and no rotate logic is built.
// Ports:
//   op_i        : operation to apply
//   d_i         : current register value
//   msb_in_i    : serial bit shifted into the MSB on SR
//   lsb_in_i    : serial bit shifted into the LSB on SL
//   data_in_i   : parallel load value
//   d_next_c_o  : resulting value (combinational)
module usr_shift_step
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  usr_mode_e          op_i,
  input  logic [WIDTH-1:0]   d_i,
  input  logic               msb_in_i,
  input  logic               lsb_in_i,
  input  logic [WIDTH-1:0]   data_in_i,
  output logic [WIDTH-1:0]   d_next_c_o
);

  // One step of the selected operation
  always_comb begin
    d_next_c_o = d_i;
    case (op_i)
      USR_SR:   d_next_c_o = {msb_in_i, d_i[WIDTH-1:1]};
      USR_SL:   d_next_c_o = {d_i[WIDTH-2:0], lsb_in_i};
      USR_LOAD: d_next_c_o = data_in_i;
`ifdef USR_ROTATE_EN
      USR_ROR:  d_next_c_o = {d_i[0], d_i[WIDTH-1:1]};
      USR_ROL:  d_next_c_o = {d_i[WIDTH-2:0], d_i[WIDTH-1]};
`endif
      USR_ASR:  d_next_c_o = {d_i[WIDTH-1], d_i[WIDTH-1:1]};
      default:  d_next_c_o = d_i;
    endcase
  end

endmodule : usr_shift_step

// File: rtl/universal_shift_reg_n.sv
// Universal shift register with single-cycle ops and a counted burst mode.
// Macro: USR_ROTATE_EN -- enables modes 4/5 (ROR/ROL); otherwise they hold.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   en_i          : clock enable; low freezes data, FSM and counter
//   mode_i        : operation code (see usr_mode_e)
//   start_i       : begin a burst of count_i steps of mode_i
//   count_i       : burst length
//   data_in_i     : parallel load value
//   msb_in_i      : serial input into MSB on SR (sampled every step)
//   lsb_in_i      : serial input into LSB on SL (sampled every step)
//   data_out_o    : register contents
//   msb_out_o     : data_out_o[WIDTH-1]
//   lsb_out_o     : data_out_o[0]
//   busy_o        : burst in progress
//   done_o        : one-cycle pulse when the final burst value is visible
module universal_shift_reg_n
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [2:0]        mode_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic [WIDTH-1:0]  data_in_i,
  input  logic              msb_in_i,
  input  logic              lsb_in_i,
  output logic [WIDTH-1:0]  data_out_o,
  output logic              msb_out_o,
  output logic              lsb_out_o,
  output logic              busy_o,
  output logic              done_o
);

  usr_state_e          state_q;
  usr_mode_e           op_q;
  usr_mode_e           step_op;
  usr_mode_e           mode_in;
  logic [WIDTH-1:0]    data_q;
  logic [WIDTH-1:0]    data_d;
  logic [WIDTH-1:0]    step_val;
  logic [CNT_W-1:0]    rem_q;
  logic                busy_q;
  logic                done_q;
  logic                zero_burst;

  assign mode_in = usr_mode_e'(mode_i);

  // The latched op drives the datapath during a burst; mode_i is ignored then
  assign step_op = (state_q == USR_RUN) ? op_q : mode_in;

  // A zero-length burst request performs no step at all
  assign zero_burst = (state_q == USR_IDLE) && start_i && (count_i == '0);

  usr_shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op_i       (step_op),
    .d_i        (data_q),
    .msb_in_i   (msb_in_i),
    .lsb_in_i   (lsb_in_i),
    .data_in_i  (data_in_i),
    .d_next_c_o (step_val)
  );

  // Data register next value
  always_comb begin
    data_d = data_q;
    if (en_i && !zero_burst) begin
      data_d = step_val;
    end
  end

  // Data register, burst FSM, step counter and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      state_q <= USR_IDLE;
      op_q    <= USR_HOLD;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      done_q <= 1'b0;
      if (en_i) begin
        case (state_q)
          USR_IDLE: begin
            if (start_i) begin
              op_q <= mode_in;
              if (count_i == '0) begin
                done_q <= 1'b1;
              end else if ((count_i == CNT_W'(1)) || usr_single_step(mode_in)) begin
                done_q <= 1'b1;
              end else begin
                // First step happens on this edge; count the rest
                rem_q   <= count_i - CNT_W'(1);
                state_q <= USR_RUN;
                busy_q  <= 1'b1;
              end
            end
          end
          USR_RUN: begin
            rem_q <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_q <= USR_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= USR_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out_o = data_q;
  assign msb_out_o  = data_q[WIDTH-1];
  assign lsb_out_o  = data_q[0];
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule : universal_shift_reg_n

// File: tb/tb_universal_shift_reg_n.sv
// Bench for universal_shift_reg_n (WIDTH=8, CNT_W=4): directed scenarios
// followed by random traffic, all compared against an arithmetic model.
module tb_universal_shift_reg_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic       start;
  logic [3:0] count;
  logic [7:0] data_in;
  logic       msb_in;
  logic       lsb_in;
  logic [7:0] data_out;
  logic       msb_out;
  logic       lsb_out;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_d    = 0;
  int m_busy = 0;
  int m_done = 0;
  int m_left = 0;
  int m_op   = 0;

  always #5 clk = ~clk;

  universal_shift_reg_n #(
    .WIDTH (8),
    .CNT_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en),
    .mode_i     (mode),
    .start_i    (start),
    .count_i    (count),
    .data_in_i  (data_in),
    .msb_in_i   (msb_in),
    .lsb_in_i   (lsb_in),
    .data_out_o (data_out),
    .msb_out_o  (msb_out),
    .lsb_out_o  (lsb_out),
    .busy_o     (busy),
    .done_o     (done)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Value after one step of op, using plain integer arithmetic on 0..255
  function automatic int apply(input int op, input int d, input int mi,
                               input int li, input int din);
    case (op)
      1: return (d / 2) + mi * 128;
      2: return ((d * 2) % 256) + li;
      3: return din;
`ifdef USR_ROTATE_EN
      4: return (d / 2) + (d % 2) * 128;
      5: return ((d * 2) % 256) + (d / 128);
`endif
      6: return (d / 2) + (d / 128) * 128;
      default: return d;
    endcase
  endfunction

  // Advance the model by one clock edge using the current inputs
  task automatic model_step();
    if (rst) begin
      m_d = 0; m_busy = 0; m_done = 0; m_left = 0; m_op = 0;
    end else if (!en) begin
      m_done = 0;
    end else begin
      m_done = 0;
      if (m_busy == 0) begin
        if (start) begin
          m_op = int'(mode);
          if (count != 0) begin
            m_d = apply(m_op, m_d, int'(msb_in), int'(lsb_in), int'(data_in));
            if (count == 1 || m_op == 0 || m_op == 3 || m_op == 7) begin
              m_done = 1;
            end else begin
              m_left = int'(count) - 1;
              m_busy = 1;
            end
          end else begin
            m_done = 1;
          end
        end else begin
          m_d = apply(int'(mode), m_d, int'(msb_in), int'(lsb_in), int'(data_in));
        end
      end else begin
        m_d = apply(m_op, m_d, int'(msb_in), int'(lsb_in), int'(data_in));
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
  endtask

  // One clock: update model at the edge, compare all outputs shortly after
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("data_out", int'(data_out), m_d);
    check("busy", int'(busy), m_busy);
    check("done", int'(done), m_done);
    check("msb_out", int'(msb_out), m_d / 128);
    check("lsb_out", int'(lsb_out), m_d % 2);
  endtask

  task automatic drive(input logic e, input logic [2:0] md, input logic st,
                       input logic [3:0] cnt, input logic [7:0] din,
                       input logic mi, input logic li);
    en = e; mode = md; start = st; count = cnt; data_in = din;
    msb_in = mi; lsb_in = li;
  endtask

  int busy_cnt;
  int done_cnt;

  initial begin
    rst = 1'b1;
    drive(1'b1, 3'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    #2;
    tick();
    tick();
    check("reset_data", int'(data_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b0;

    // 1: load, SR, SL
    drive(1'b1, 3'd3, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0); tick();
    check("load_a5", int'(data_out), 'hA5);
    drive(1'b1, 3'd1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0); tick();
    check("sr_d2", int'(data_out), 'hD2);
    drive(1'b1, 3'd2, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0); tick();
    check("sl_a4", int'(data_out), 'hA4);

    // 2: ASR, ROL
    drive(1'b1, 3'd3, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0); tick();
    drive(1'b1, 3'd6, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0); tick();
    check("asr_c0", int'(data_out), 'hC0);
    drive(1'b1, 3'd5, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0); tick();
`ifdef USR_ROTATE_EN
    check("rol_81", int'(data_out), 'h81);
`else
    check("rol_held", int'(data_out), 'hC0);
`endif

    // 3: SL burst of 5 from 0x01
    drive(1'b1, 3'd3, 1'b0, 4'd0, 8'h01, 1'b0, 1'b0); tick();
    drive(1'b1, 3'd2, 1'b1, 4'd5, 8'h00, 1'b0, 1'b0);
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      drive(1'b1, 3'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    end
    check("burst5_busy_cycles", busy_cnt, 4);
    check("burst5_done_cycles", done_cnt, 1);
    check("burst5_data", int'(data_out), 'h20);

    // 4: SR burst of 6 with en gap and an ignored start
    drive(1'b1, 3'd3, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0); tick();
    drive(1'b1, 3'd1, 1'b1, 4'd6, 8'h00, 1'b1, 1'b0); tick();
    drive(1'b1, 3'd0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0); tick(); tick();
    drive(1'b0, 3'd3, 1'b1, 4'd2, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gap_frozen", int'(data_out), 'hE0);
    end
    drive(1'b1, 3'd3, 1'b1, 4'd2, 8'h55, 1'b1, 1'b0); tick();
    drive(1'b1, 3'd0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0); tick();
    check("gap_no_early_done", int'(done), 0);
    tick();
    check("gap_done", int'(done), 1);
    check("gap_data", int'(data_out), 'hFC);
    check("gap_busy_clear", int'(busy), 0);

    // 5: zero-length burst
    drive(1'b1, 3'd3, 1'b0, 4'd0, 8'h3C, 1'b0, 1'b0); tick();
    drive(1'b1, 3'd1, 1'b1, 4'd0, 8'h00, 1'b1, 1'b1); tick();
    check("zero_done", int'(done), 1);
    check("zero_busy", int'(busy), 0);
    check("zero_data", int'(data_out), 'h3C);
    drive(1'b1, 3'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0); tick();
    check("zero_done_pulse", int'(done), 0);

    // 6: reset mid-burst
    drive(1'b1, 3'd3, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0); tick();
    drive(1'b1, 3'd2, 1'b1, 4'd8, 8'h00, 1'b0, 1'b1); tick();
    drive(1'b1, 3'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("abort_data", int'(data_out), 0);
    check("abort_busy", int'(busy), 0);
    drive(1'b1, 3'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1); tick(); tick();
    check("abort_no_done", int'(done), 0);
    drive(1'b1, 3'd3, 1'b0, 4'd0, 8'h5A, 1'b0, 1'b0); tick();
    check("after_abort_load", int'(data_out), 'h5A);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      rst     = ($urandom % 64) == 0;
      en      = ($urandom % 8) != 0;
      mode    = 3'($urandom);
      start   = ($urandom % 4) == 0;
      count   = 4'($urandom);
      data_in = 8'($urandom);
      msb_in  = 1'($urandom);
      lsb_in  = 1'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_universal_shift_reg_n
